scic_cpu_ws: RTL
================

// Module: scic_cpu_ws
// PURPOSE
//  Parametrised accumulator CPU; next generation of the SCIC fetch/execute core.
//  Adds a ready/valid memory handshake with wait states, ADD/SUB/XOR, conditional
//  branches and HALT. Connects to one shared instruction/data memory port.
//  Intended as the drop-in core for SoC builds with slow or arbitrated memory.
// PARAMETERS
//  DATA_W    32  accumulator/instruction/memory data width; must be >= ADDR_W+4
//  ADDR_W    16  memory address width; PC width; operand field = IR[ADDR_W-1:0]
//  RESET_PC  0   PC value loaded on reset (ADDR_W bits)
// PORTS
//  clock      in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  mem_req    out  1       memory transaction request
//  mem_we     out  1       1 = write (store), 0 = read; valid only while mem_req=1
//  mem_addr   out  ADDR_W  transaction address
//  mem_wdata  out  DATA_W  store data (= AC)
//  mem_ready  in   1       memory accepts/completes the transaction this cycle
//  mem_rdata  in   DATA_W  read data; sampled only when mem_req & mem_ready
//  halted     out  1       core is in HALT state
//  pc_out     out  ADDR_W  current PC (debug)
//  ac_out     out  DATA_W  current AC (debug)
// BEHAVIOUR
//  Reset: state=FETCH, PC=RESET_PC, AC=0, IR=0; so mem_req=1, mem_we=0,
//   mem_addr=RESET_PC, halted=0 in the first cycle after reset.
//  Handshake: a transaction completes on a rising edge where mem_req&mem_ready.
//   While mem_req=1 & mem_ready=0, mem_addr/mem_we/mem_wdata and all state hold.
//  Opcode = IR[DATA_W-1:DATA_W-4]; operand X = IR[ADDR_W-1:0]; M = mem[X].
//  States:
//   FETCH: req=1, we=0, addr=PC. On completion IR<=rdata, PC<=PC+1 (wraps mod
//    2^ADDR_W), -> EXEC.
//   EXEC, memory ops (ADD,SHL,SHR,LD,OR,ST,AND,SUB,XOR): req=1, addr=X,
//    we=1 only for ST. On completion update AC, -> FETCH.
//   EXEC, non-memory ops (NOP,LDI,JMP,JZ,JN,reserved): req=0; 1 cycle, -> FETCH.
//   EXEC, HLT: req=0, -> HALT.
//   HALT: req=0, halted=1, all registers frozen; exit only by reset.
//  Opcodes:
//   0000 NOP | 0001 ADD AC+=M | 0010 SHL AC<<=M | 0011 SHR AC>>=M (logical)
//   0100 LDI AC={0,X} | 0101 LD AC=M | 0110 OR AC|=M | 0111 ST M=AC
//   1000 JMP PC=X | 1001 AND AC&=M | 1010 SUB AC-=M | 1011 JZ if AC==0 PC=X
//   1100 JN if AC[DATA_W-1] PC=X | 1101 XOR AC^=M | 1110 NOP | 1111 HLT
//  Arithmetic: ADD/SUB wrap mod 2^DATA_W, no flags; shift amount = full M,
//   amounts >= DATA_W give AC=0.
//  Timing with zero wait states: 2 cycles per instruction; each wait cycle adds 1.
//  Branch to X takes effect for the next FETCH; not-taken JZ/JN leave PC = PC+1.
//  Reset has priority over everything, including an in-flight stalled transaction:
//   the pending request is abandoned and no write is counted as completed.
//  mem_rdata ignored whenever mem_req=0 or mem_ready=0.
// TESTING
//  1 mem_ready=1: LDI 5; ADD [0x20]=7; ST [0x21]; HLT -> mem[0x21]=12, halted
//    after 8 cycles, pc_out=4.
//  2 Same program, mem_ready low 3 cycles per transaction -> identical result,
//    addr/we/wdata stable during every stall, halted after 8+6*3 cycles.
//  3 LDI 0; JZ 0x10; LDI 1; JN 0x30 -> PC=0x10 taken; with AC=0x80000000, JN taken,
//    with AC=1, JN not taken (PC=next).
//  4 SUB with AC=0, M=1 -> AC=0xFFFFFFFF; SHL by 32 -> AC=0; SHR by 4 of 0xF0 -> 0xF.
//  5 RESET_PC=0xFFFF, JMP at 0xFFFF fetched -> PC wraps to 0x0000 before execute.
//  6 Assert reset during a stalled ST (mem_ready=0) -> next cycle mem_we=0,
//    mem_addr=RESET_PC, AC=0, no store observed at target address.

Source files
------------

// File: rtl/scic_cpu_ws.sv
// Accumulator CPU with a single shared instruction/data port and ready/valid wait states.
// Every state change and memory output is registered; a stalled transaction freezes everything.
module scic_cpu_ws #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] ac_out
);

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'h1;
    localparam logic [OP_W-1:0] OP_SHL = 4'h2;
    localparam logic [OP_W-1:0] OP_SHR = 4'h3;
    localparam logic [OP_W-1:0] OP_LDI = 4'h4;
    localparam logic [OP_W-1:0] OP_LD  = 4'h5;
    localparam logic [OP_W-1:0] OP_OR  = 4'h6;
    localparam logic [OP_W-1:0] OP_ST  = 4'h7;
    localparam logic [OP_W-1:0] OP_JMP = 4'h8;
    localparam logic [OP_W-1:0] OP_AND = 4'h9;
    localparam logic [OP_W-1:0] OP_SUB = 4'hA;
    localparam logic [OP_W-1:0] OP_JZ  = 4'hB;
    localparam logic [OP_W-1:0] OP_JN  = 4'hC;
    localparam logic [OP_W-1:0] OP_XOR = 4'hD;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_ac;
    logic [OP_W-1:0]     r_op;
    logic [ADDR_W-1:0]   r_x;
    logic                r_req;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_halted;

    logic                w_done;
    logic [OP_W-1:0]     w_f_op;
    logic [ADDR_W-1:0]   w_f_x;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic                w_taken;
    logic [ADDR_W-1:0]   w_next_pc;
    logic [DATA_W-1:0]   w_alu;

    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SHL, OP_SHR, OP_LD, OP_OR,
            OP_ST, OP_AND, OP_SUB, OP_XOR: is_mem_op = 1'b1;
            default:                       is_mem_op = 1'b0;
        endcase
    endfunction

    assign w_done    = r_req & mem_ready;
    assign w_f_op    = mem_rdata[DATA_W-1 -: OP_W];
    assign w_f_x     = mem_rdata[ADDR_W-1:0];
    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_taken   = (r_op == OP_JMP)
                     | ((r_op == OP_JZ) & (r_ac == '0))
                     | ((r_op == OP_JN) & r_ac[DATA_W-1]);
    assign w_next_pc = w_taken ? r_x : r_pc;

    // Memory-operand result; shifts by >= DATA_W naturally yield zero.
    always_comb begin
        w_alu = r_ac;
        case (r_op)
            OP_ADD:  w_alu = r_ac + mem_rdata;
            OP_SUB:  w_alu = r_ac - mem_rdata;
            OP_SHL:  w_alu = r_ac << mem_rdata;
            OP_SHR:  w_alu = r_ac >> mem_rdata;
            OP_LD:   w_alu = mem_rdata;
            OP_OR:   w_alu = r_ac | mem_rdata;
            OP_AND:  w_alu = r_ac & mem_rdata;
            OP_XOR:  w_alu = r_ac ^ mem_rdata;
            default: w_alu = r_ac;
        endcase
    end

    // Fetch/execute sequencer; memory outputs are set up one edge ahead of use.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_ac     <= '0;
            r_op     <= '0;
            r_x      <= '0;
            r_req    <= 1'b1;
            r_we     <= 1'b0;
            r_addr   <= RESET_PC;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_done) begin
                        r_op    <= w_f_op;
                        r_x     <= w_f_x;
                        r_pc    <= w_pc_inc;
                        r_state <= S_EXEC;
                        r_req   <= is_mem_op(w_f_op);
                        r_we    <= (w_f_op == OP_ST);
                        r_addr  <= w_f_x;
                    end
                end
                S_EXEC: begin
                    if (r_req) begin
                        if (mem_ready) begin
                            r_ac    <= w_alu;
                            r_state <= S_FETCH;
                            r_we    <= 1'b0;
                            r_addr  <= r_pc;
                        end
                    end else if (r_op == OP_HLT) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        if (r_op == OP_LDI) begin
                            r_ac <= DATA_W'(r_x);
                        end
                        r_pc    <= w_next_pc;
                        r_addr  <= w_next_pc;
                        r_req   <= 1'b1;
                        r_we    <= 1'b0;
                        r_state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_req <= 1'b0;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_ac;
    assign halted    = r_halted;
    assign pc_out    = r_pc;
    assign ac_out    = r_ac;

endmodule
